// File: rtl/cpu_pkg.sv
// Shared types and sizes for the instruction sequencer slice.
// Optional build macro used by pc_sequencer: PC_STACK_OVF_TRAP_EN.
package cpu_pkg;

    localparam int PC_W           = 12;
    localparam int INST_W         = 16;
    localparam int PC_STACK_DEPTH = 8;
    localparam int DEPTH_W        = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    // Sequential successor of a program counter; wraps 0xFFF -> 0x000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
        return p + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO built as a shift register: entry 0 is the top.
// A push while full shifts the oldest entry out and leaves depth at max.
module pc_stack
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [PC_W-1:0]    din,
    output logic [PC_W-1:0]    top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [PC_W-1:0]    r_entries [PC_STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;

    // Entry storage: shift down on push, shift up on pop; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_entries[0] <= din;
            for (int unsigned i = 1; i < PC_STACK_DEPTH; i++) begin
                r_entries[i] <= r_entries[i-1];
            end
        end else if (pop) begin
            for (int unsigned i = 0; i < PC_STACK_DEPTH - 1; i++) begin
                r_entries[i] <= r_entries[i+1];
            end
        end
    end

    // Occupancy counter; saturates at full because overflow discards the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
        end else if (push) begin
            if (!full) r_depth <= r_depth + 1'b1;
        end else if (pop && !empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign top   = r_entries[0];
    assign depth = r_depth;
    assign full  = (r_depth == DEPTH_W'(PC_STACK_DEPTH));
    assign empty = (r_depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch/execute sequencer with program counter and call stack.
// Build macro PC_STACK_OVF_TRAP_EN: when defined, a call with a full stack
// faults and halts; otherwise the oldest return address is discarded.
module pc_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INST_W-1:0]  imem_data,
    output logic [INST_W-1:0]  inst,
    output logic               inst_valid,
    input  logic               pc_we,
    input  logic [PC_W-1:0]    pc_inp,
    input  logic               call,
    input  logic               ret,
    input  logic               stall,
    output logic [PC_W-1:0]    pc,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               fault
);

    seq_state_t          r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INST_W-1:0]   r_inst;
    logic                r_imem_req;
    logic                r_inst_valid;
    logic                r_fault;

    logic                w_exec_go;
    logic                w_trap;
    logic                w_push;
    logic                w_pop;
    logic [PC_W-1:0]     w_pc_next;
    logic [PC_W-1:0]     w_top;
    logic [DEPTH_W-1:0]  w_depth;
    logic                w_full;
    logic                w_empty;

    pc_stack u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pc_inc(r_pc)),
        .top   (w_top),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    // Resolve the EXEC-cycle flow request: ret > call > pc_we > increment.
    always_comb begin
        w_exec_go = (r_state == S_EXEC) && !stall;
        w_trap    = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_pc_next = r_pc;
        if (w_exec_go) begin
            if (ret) begin
                if (w_empty) begin
                    w_trap = 1'b1;
                end else begin
                    w_pop     = 1'b1;
                    w_pc_next = w_top;
                end
            end else if (call) begin
`ifdef PC_STACK_OVF_TRAP_EN
                if (w_full) begin
                    w_trap = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_pc_next = pc_inp;
                end
`else
                w_push    = 1'b1;
                w_pc_next = pc_inp;
`endif
            end else if (pc_we) begin
                w_pc_next = pc_inp;
            end else begin
                w_pc_next = pc_inc(r_pc);
            end
        end
    end

    // Sequencer FSM with registered fetch request, instruction latch and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_inst       <= '0;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_inst       <= imem_data;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_exec_go) begin
                        r_inst_valid <= 1'b0;
                        if (w_trap) begin
                            r_fault <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_pc       <= w_pc_next;
                            r_imem_req <= run;
                            r_state    <= run ? S_FETCH : S_IDLE;
                        end
                    end
                end
                default: begin
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_valid  = r_inst_valid;
    assign pc          = r_pc;
    assign stack_depth = w_depth;
    assign fault       = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner
// sequences and randomized transactions against a queue-based model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] inst;
    logic        inst_valid;
    logic        pc_we = 1'b0;
    logic [11:0] pc_inp = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        stall = 1'b0;
    logic [11:0] pc;
    logic [3:0]  stack_depth;
    logic        fault;

`ifdef PC_STACK_OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_pc;
    int          m_stk[$];
    bit          m_fault;
    logic [15:0] m_inst;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .inst(inst), .inst_valid(inst_valid),
        .pc_we(pc_we), .pc_inp(pc_inp),
        .call(call), .ret(ret), .stall(stall),
        .pc(pc), .stack_depth(stack_depth), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: one executed instruction, straight from the flow rules.
    task automatic model_exec(input bit r, input bit c, input bit w, input int inp);
        if (r) begin
            if (m_stk.size() == 0) m_fault = 1'b1;
            else m_pc = m_stk.pop_front();
        end else if (c) begin
            if (m_stk.size() == 8 && OVF_TRAP) begin
                m_fault = 1'b1;
            end else begin
                if (m_stk.size() == 8) void'(m_stk.pop_back());
                m_stk.push_front((m_pc + 1) % 4096);
                m_pc = inp;
            end
        end else if (w) begin
            m_pc = inp;
        end else begin
            m_pc = (m_pc + 1) % 4096;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_pc", pc, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_depth", stack_depth, 0);
        check("rst_fault", fault, 0);
        run = 0; imem_ack = 0; stall = 0; call = 0; ret = 0; pc_we = 0;
        tick;
        rst = 1'b0;
        m_pc = 0; m_stk.delete(); m_fault = 0; m_inst = '0;
    endtask

    task automatic start_run;
        run = 1'b1;
        tick;
    endtask

    // Act as instruction memory for one fetch; ack after 'delay' idle cycles.
    task automatic do_fetch(input logic [15:0] data, input int delay);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            tick;
            check("fetch_req_held", imem_req, 1);
        end
        imem_ack = 1'b1;
        imem_data = data;
        tick;
        imem_ack = 1'b0;
        m_inst = data;
        check("exec_inst", inst, data);
        check("exec_valid", inst_valid, 1);
        check("exec_req_low", imem_req, 0);
    endtask

    task automatic do_exec(input bit r, input bit c, input bit w, input logic [11:0] inp,
                           input int stalls, input bit runv);
        ret = r; call = c; pc_we = w; pc_inp = inp;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            tick;
            check("stall_pc", pc, m_pc);
            check("stall_depth", stack_depth, m_stk.size());
            check("stall_valid", inst_valid, 1);
            check("stall_inst", inst, m_inst);
        end
        stall = 1'b0;
        run = runv;
        tick;
        ret = 0; call = 0; pc_we = 0;
        model_exec(r, c, w, inp);
        check("exec_pc", pc, m_pc);
        check("exec_depth", stack_depth, m_stk.size());
        check("exec_fault", fault, m_fault);
        check("exec_valid_drop", inst_valid, 0);
        check("exec_next_req", imem_req, (runv && !m_fault) ? 1 : 0);
    endtask

    task automatic check_halt_hold(input int cycles);
        run = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick;
            check("halt_req", imem_req, 0);
            check("halt_valid", inst_valid, 0);
            check("halt_fault", fault, 1);
            check("halt_pc", pc, m_pc);
        end
    endtask

    typedef struct {
        logic [11:0] jump_pc;
        bit          pre_call;
        logic [11:0] call_pc;
        bit          r, c, w;
        logic [11:0] inp;
        logic [11:0] exp_pc;
        int          exp_depth;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{12'h010, 1, 12'h200, 1, 0, 0, 12'h000, 12'h011, 0, 0};
        vecs[1] = '{12'h054, 1, 12'h300, 1, 1, 1, 12'h123, 12'h055, 0, 0};
        vecs[2] = '{12'h100, 0, 12'h000, 0, 1, 1, 12'h222, 12'h222, 1, 0};
        vecs[3] = '{12'h100, 0, 12'h000, 0, 0, 1, 12'h0AB, 12'h0AB, 0, 0};
        vecs[4] = '{12'hFFF, 0, 12'h000, 0, 0, 0, 12'h000, 12'h000, 0, 0};
        vecs[5] = '{12'h020, 0, 12'h000, 1, 0, 0, 12'h000, 12'h020, 0, 1};
        vecs[6] = '{12'h020, 1, 12'h400, 0, 0, 0, 12'h000, 12'h401, 1, 0};
        vecs[7] = '{12'h100, 1, 12'h500, 0, 1, 0, 12'h600, 12'h600, 2, 0};

        // Sequential fetch with immediate acks: addresses 0,1,2 and one-cycle inst_valid
        do_reset;
        start_run;
        for (int k = 0; k < 3; k++) begin
            check("seq_addr", imem_addr, k);
            do_fetch(16'hA000 + 16'(k), 0);
            do_exec(0, 0, 0, 12'h000, 0, 1);
        end

        // Vector table
        foreach (vecs[i]) begin
            do_reset;
            start_run;
            do_fetch(16'h1111, 0);
            do_exec(0, 0, 1, vecs[i].jump_pc, 0, 1);
            if (vecs[i].pre_call) begin
                do_fetch(16'h2222, 1);
                do_exec(0, 1, 0, vecs[i].call_pc, 0, 1);
            end
            do_fetch(16'h3333, 0);
            do_exec(vecs[i].r, vecs[i].c, vecs[i].w, vecs[i].inp, 1, 1);
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_depth", i), stack_depth, vecs[i].exp_depth);
            check($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
        end

        // Underflow: halt holds with no fetch until reset
        do_reset;
        start_run;
        do_fetch(16'h4444, 0);
        do_exec(1, 0, 0, 12'h000, 0, 1);
        check("underflow_fault", fault, 1);
        check_halt_hold(4);

        // Push at 0xFFF stores 0x000; increment wraps fetch address
        do_reset;
        start_run;
        do_fetch(16'h5555, 0);
        do_exec(0, 0, 1, 12'hFFF, 0, 1);
        do_fetch(16'h5556, 0);
        do_exec(0, 1, 0, 12'h010, 0, 1);
        do_fetch(16'h5557, 0);
        do_exec(1, 0, 0, 12'h000, 0, 1);
        check("wrap_ret_pc", pc, 0);

        // Nine nested calls, then drain
        do_reset;
        start_run;
        for (int k = 0; k < 9; k++) begin
            if (fault) break;
            do_fetch(16'h6000 + 16'(k), 0);
            do_exec(0, 1, 0, 12'h100 * 12'(k + 1), 0, 1);
        end
        check("nest9_depth", stack_depth, 8);
        check("nest9_fault", fault, OVF_TRAP);
        if (!OVF_TRAP) begin
            for (int k = 0; k < 9; k++) begin
                do_fetch(16'h7000 + 16'(k), 0);
                do_exec(1, 0, 0, 12'h000, 0, 1);
            end
            check("nest9_drain_fault", fault, 1);
        end
        check_halt_hold(2);

        // Reset during fetch with ack pending, and during a stall
        do_reset;
        start_run;
        check("midfetch_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_data = 16'hBEEF;
        do_reset;
        start_run;
        do_fetch(16'h8888, 0);
        do_exec(0, 1, 0, 12'h345, 0, 1);
        do_fetch(16'h8889, 0);
        stall = 1'b1;
        tick;
        do_reset;

        // Randomized transactions
        start_run;
        for (int n = 0; n < 400; n++) begin
            bit r, c, w, runv;
            r    = ($urandom_range(0, 5) == 0);
            c    = ($urandom_range(0, 3) == 0);
            w    = ($urandom_range(0, 3) == 0);
            runv = ($urandom_range(0, 7) != 0);
            do_fetch(16'($urandom), $urandom_range(0, 2));
            do_exec(r, c, w, 12'($urandom), $urandom_range(0, 2), runv);
            if (m_fault) begin
                check_halt_hold(2);
                do_reset;
                start_run;
            end else if (!runv) begin
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                    tick;
                    check("idle_req", imem_req, 0);
                end
                start_run;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port run  input  1  enables fetching; sampled in IDLE and at the end of EXEC.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request, held until imem_ack.
REQ-005 SHALL have port imem_addr  output  12  fetch address, equals pc while imem_req=1.
REQ-006 SHALL have port imem_ack  input  1  memory returns imem_data this cycle.
REQ-007 SHALL have port imem_data  input  16  fetched instruction word.
REQ-008 SHALL have port inst  output  16  latched current instruction, drives flow-control/ALU decode.
REQ-009 SHALL have port inst_valid  output  1  high for exactly the EXEC cycle(s) of inst.
REQ-010 SHALL have ports pc_we  input  1  and pc_inp  input  12  jump request/target from flow-control unit.
REQ-011 SHALL have ports call  input  1  and ret  input  1  subroutine push/pop requests, sampled in EXEC.
REQ-012 SHALL have port stall  input  1  holds EXEC while high.
REQ-013 SHALL have ports pc  output  12, stack_depth  output  4 (0..8), fault  output  1.

Function
REQ-014 SHALL implement states IDLE, FETCH, EXEC, HALT; IDLE->FETCH when run=1.
REQ-015 FETCH SHALL assert imem_req with imem_addr=pc; on imem_ack latch imem_data into inst and enter EXEC next cycle (fetch latency = ack cycle + 1).
REQ-016 EXEC SHALL stay while stall=1 with pc, stack and inst unchanged; on the first cycle stall=0 it SHALL update pc and go to FETCH if run=1, else IDLE.
REQ-017 PC update priority in EXEC SHALL be: ret > call > pc_we > increment; lower-priority requests in the same cycle SHALL be ignored.
REQ-018 ret SHALL pop: pc<=top entry, depth-1.
REQ-019 call SHALL push pc+1 (12-bit wrap) and set pc<=pc_inp, depth+1.
REQ-020 pc_we alone SHALL set pc<=pc_inp; no request SHALL set pc<=pc+1.
REQ-021 Increment SHALL wrap 0xFFF->0x000; pushing at pc=0xFFF SHALL store 0x000.
REQ-022 ret with depth=0 SHALL set fault=1, leave pc unchanged and enter HALT.
REQ-023 HALT SHALL hold all state with imem_req=0 and inst_valid=0 and exit only on rst.
REQ-024 fault SHALL be sticky until rst.

Reset
REQ-025 rst SHALL immediately force state=IDLE, pc=0x000, inst=0x0000, depth=0, fault=0, imem_req=0, inst_valid=0, including mid-fetch or mid-stall.
REQ-026 Stack entry contents SHALL NOT require reset; entries beyond depth SHALL never be observable.

Configuration
REQ-027 Macro PC_STACK_OVF_TRAP_EN SHALL select behaviour of call with depth=8.
REQ-028 With PC_STACK_OVF_TRAP_EN defined: fault=1, no push, pc unchanged, enter HALT.
REQ-029 Without it: the oldest entry SHALL be discarded, the new entry pushed, depth stays 8, pc<=pc_inp, fault unchanged.

Structure
REQ-030 Package cpu_pkg SHALL hold PC_W=12, INST_W=16, PC_STACK_DEPTH=8 and the state enum type.
REQ-031 Stack SHALL be sub-module pc_stack (shift-register LIFO with push, pop, top, depth, full, empty).

Verification
REQ-032 Reset, run=1, memory acks every fetch immediately, no requests -> imem_addr sequence 0x000,0x001,0x002; inst_valid one cycle each.
REQ-033 EXEC at pc=0x010, call=1, pc_inp=0x200 -> pc=0x200, depth=1; later ret=1 -> pc=0x011, depth=0.
REQ-034 call=1, ret=1, pc_we=1 in the same EXEC cycle with depth=1, top=0x055 -> pc=0x055, depth=0.
REQ-035 ret with depth=0 -> fault=1, HALT, imem_req stays 0 until rst.
REQ-036 9 nested calls: with macro -> fault at 9th call, depth=8; without -> no fault, depth=8, 8 pops return the 8 newest return addresses, 9th pop faults.
REQ-037 pc=0xFFF increments -> next imem_addr=0x000; rst asserted during FETCH with imem_ack pending -> imem_req=0 in the same cycle, pc=0x000.
